// File: rtl/spi_controller.sv
// spi_controller
//   SPI mode-0 initiator for the 3-wire register link (sclk, copi, ncs).
//   Each accepted request sends one 16-bit frame {rw, addr[6:0], wdata[7:0]},
//   MSB first. cipo is sampled on every SCLK rising edge, and the last eight
//   samples are presented on rdata when the frame completes.
//
// Parameters
//   CLK_DIV  clk cycles per SCLK half-period (>= 2; >= 4 when the far end
//            synchronises SCLK into its own clock domain)
//
// Ports
//   clk, rst_n         system clock, asynchronous active-low reset
//   start              request pulse; taken only while busy=0
//   rw, addr, wdata    frame fields, latched when the request is accepted
//   cipo               serial data from the peripheral
//   busy               frame in progress (cycle after accept up to done, exclusive)
//   done               one-cycle completion pulse
//   rdata              byte captured from cipo during the data byte
//   sclk, copi, ncs    SPI clock (idles low), serial out, chip select (active low)
//
// State table
//   state   | meaning
//   S_IDLE  | waiting for start; ncs high, sclk low, copi low
//   S_SETUP | ncs low, copi = bit 15; doubles as the low half of bit 15
//   S_SHIFT | SCLK high half / low half per bit, bit 15 down to bit 0
//   S_HOLD  | sclk low after bit 0; ncs still low, copi keeps bit 0
//   S_GAP   | ncs high; last cycle is the done cycle and can accept a new start

module spi_controller #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    input  logic       cipo,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic       sclk,
    output logic       copi,
    output logic       ncs
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_GAP
    } state_t;

    state_t           state, state_nxt;
    logic [DIV_W-1:0] div_cnt;
    logic             div_tc;
    logic             high_half, high_nxt;
    logic [3:0]       bit_cnt;
    logic [15:0]      shreg;
    logic [7:0]       rx_byte;
    logic             accept;
    logic             shift_out;
    logic             sclk_rise;

    assign div_tc    = (div_cnt == '0);
    // First cycle of a high half is the cycle in which sclk goes 0->1.
    assign sclk_rise = (state == S_SHIFT) && high_half && (div_cnt == DIV_LAST);

    always_comb begin
        state_nxt = state;
        high_nxt  = high_half;
        accept    = 1'b0;
        shift_out = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = S_SETUP;
                end
            end
            S_SETUP: begin
                if (div_tc) begin
                    state_nxt = S_SHIFT;
                    high_nxt  = 1'b1;
                end
            end
            S_SHIFT: begin
                if (div_tc) begin
                    if (high_half) begin
                        high_nxt = 1'b0;
                        if (bit_cnt == 4'd0) begin
                            state_nxt = S_HOLD;
                        end else begin
                            shift_out = 1'b1;
                        end
                    end else begin
                        high_nxt = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (div_tc) begin
                    state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                // The final GAP cycle is the done cycle; a start here chains
                // the next frame so ncs stays high for exactly one GAP.
                if (div_tc) begin
                    busy = 1'b0;
                    done = 1'b1;
                    if (start) begin
                        accept    = 1'b1;
                        state_nxt = S_SETUP;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            high_half <= 1'b0;
        end else begin
            state     <= state_nxt;
            high_half <= high_nxt;
        end
    end

    // Half-period timer: reloads at terminal count and is parked while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= DIV_LAST;
        end else if (div_tc || state == S_IDLE) begin
            div_cnt <= DIV_LAST;
        end else begin
            div_cnt <= div_cnt - DIV_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= 4'd0;
            shreg   <= 16'd0;
        end else if (accept) begin
            bit_cnt <= 4'd15;
            shreg   <= {rw, addr, wdata};
        end else if (shift_out) begin
            bit_cnt <= bit_cnt - 4'd1;
            shreg   <= {shreg[14:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_byte <= 8'd0;
        end else if (sclk_rise) begin
            rx_byte <= {rx_byte[6:0], cipo};
        end
    end

    // Loaded one cycle before the done cycle so rdata is already valid
    // while done is high. GAP is always at least two cycles long.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= 8'd0;
        end else if (state == S_GAP && div_cnt == DIV_ONE) begin
            rdata <= rx_byte;
        end
    end

    assign ncs  = !(state == S_SETUP || state == S_SHIFT || state == S_HOLD);
    assign sclk = (state == S_SHIFT) && high_half;
    assign copi = ncs ? 1'b0 : shreg[15];

endmodule

// File: tb/tb_spi_controller.sv
// tb_spi_controller
//   Self-checking bench for spi_controller (CLK_DIV=4). A passive SPI monitor
//   decodes the frame from sclk/copi, records cipo at each rising edge, and
//   measures ncs timing; table vectors, hand sequences and random frames are
//   compared against values derived from the frame format.

module tb_spi_controller;

    localparam int N = 4;

    typedef struct {
        logic        rw;
        logic [6:0]  addr;
        logic [7:0]  wdata;
        logic [15:0] exp_frame;
        logic [7:0]  exp_rdata;
    } vec_t;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       start    = 1'b0;
    logic       rw       = 1'b0;
    logic [6:0] addr     = 7'd0;
    logic [7:0] wdata    = 8'd0;
    logic       cipo_rnd = 1'b0;
    logic       loop_en  = 1'b0;
    logic       cipo;
    logic       busy, done, sclk, copi, ncs;
    logic [7:0] rdata;

    assign cipo = loop_en ? copi : cipo_rnd;

    always #5 clk = ~clk;

    spi_controller #(.CLK_DIV(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .rw    (rw),
        .addr  (addr),
        .wdata (wdata),
        .cipo  (cipo),
        .busy  (busy),
        .done  (done),
        .rdata (rdata),
        .sclk  (sclk),
        .copi  (copi),
        .ncs   (ncs)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // SPI monitor state
    int          mon_edges     = 0;
    int          done_cnt      = 0;
    int          viol          = 0;
    int          ncs_low_run   = 0;
    int          ncs_high_run  = 0;
    int          last_ncs_low  = 0;
    int          last_ncs_high = 0;
    logic [15:0] mon_frame     = 16'd0;
    logic [7:0]  mon_rx        = 8'd0;

    initial begin
        logic p_sclk, p_ncs, p_copi, cval;
        p_sclk = 1'b0;
        p_ncs  = 1'b1;
        p_copi = 1'b0;
        forever begin
            @(negedge clk);
            cipo_rnd = 1'($urandom_range(1));
            cval     = loop_en ? copi : cipo_rnd;
            if (rst_n) begin
                if (sclk && !p_sclk) begin
                    if (ncs) viol++;
                    if (copi != p_copi) viol++;
                    mon_edges++;
                    mon_frame = {mon_frame[14:0], copi};
                    mon_rx    = {mon_rx[6:0], cval};
                end
                if (ncs != p_ncs && (sclk || p_sclk)) viol++;
            end
            if (!ncs && p_ncs) begin
                last_ncs_high = ncs_high_run;
                ncs_low_run   = 0;
                mon_edges     = 0;
                mon_frame     = 16'd0;
                mon_rx        = 8'd0;
            end
            if (ncs && !p_ncs) begin
                last_ncs_low = ncs_low_run;
                ncs_high_run = 0;
            end
            if (ncs) ncs_high_run++;
            else     ncs_low_run++;
            if (done) done_cnt++;
            p_sclk = sclk;
            p_ncs  = ncs;
            p_copi = copi;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    int accept_cyc = 0;
    int done_base  = 0;
    int done_cyc   = 0;

    // Waits for busy=0 and drives a one-cycle start pulse; returns one cycle later.
    task automatic start_frame(input logic r, input logic [6:0] a, input logic [7:0] d);
        int k;
        k = 0;
        #1;
        while (busy && k < 400) begin
            @(negedge clk);
            #1;
            k++;
        end
        check("idle_before_start", 32'(busy), 32'd0);
        rw         = r;
        addr       = a;
        wdata      = d;
        start      = 1'b1;
        accept_cyc = cyc;
        done_base  = done_cnt;
        @(negedge clk);
        #1;
        start = 1'b0;
    endtask

    // Waits for done and checks the completed frame; returns inside the done cycle.
    task automatic finish_frame(input logic [15:0] exp_frame, input logic chk_rd,
                                input logic [7:0] exp_rd, input string tag);
        int k;
        k = 0;
        while (!done && k < 600) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (!done) begin
            check({tag, "_done_timeout"}, 32'd0, 32'd1);
            return;
        end
        done_cyc = cyc;
        check({tag, "_frame"},     32'(mon_frame), 32'(exp_frame));
        check({tag, "_edges"},     32'(mon_edges), 32'd16);
        check({tag, "_ncs_low"},   32'(last_ncs_low), 32'(33 * N));
        // accept cycle and done cycle both counted
        check({tag, "_latency"},   32'(cyc - accept_cyc + 1), 32'(34 * N + 1));
        check({tag, "_done_once"}, 32'(done_cnt - done_base), 32'd1);
        check({tag, "_busy_low"},  32'(busy), 32'd0);
        check({tag, "_rdata"},     32'(rdata), chk_rd ? 32'(exp_rd) : 32'(mon_rx));
    endtask

    initial begin
        vec_t       tbl[4];
        logic       r;
        logic [6:0] a;
        logic [7:0] d;
        int         k, base;

        tbl[0] = '{1'b1, 7'h00, 8'hA5, 16'h80A5, 8'hA5};
        tbl[1] = '{1'b0, 7'h04, 8'h3C, 16'h043C, 8'h3C};
        tbl[2] = '{1'b1, 7'h7F, 8'hFF, 16'hFFFF, 8'hFF};
        tbl[3] = '{1'b0, 7'h55, 8'h0F, 16'h550F, 8'h0F};

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_ncs",   32'(ncs),   32'd1);
        check("rst_sclk",  32'(sclk),  32'd0);
        check("rst_copi",  32'(copi),  32'd0);
        check("rst_busy",  32'(busy),  32'd0);
        check("rst_done",  32'(done),  32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Table vectors in loopback
        loop_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            start_frame(tbl[i].rw, tbl[i].addr, tbl[i].wdata);
            finish_frame(tbl[i].exp_frame, 1'b1, tbl[i].exp_rdata, $sformatf("vec%0d", i));
        end
        repeat (5) @(negedge clk);

        // start while busy is ignored
        loop_en = 1'b0;
        start_frame(1'b0, 7'h12, 8'h34);
        repeat (9) begin
            @(negedge clk);
            #1;
        end
        check("busy_at_restart", 32'(busy), 32'd1);
        rw    = 1'b1;
        addr  = 7'h7F;
        wdata = 8'hFF;
        start = 1'b1;
        @(negedge clk);
        #1;
        start = 1'b0;
        rw    = 1'b0;
        addr  = 7'h00;
        wdata = 8'h00;
        finish_frame(16'h1234, 1'b0, 8'h00, "ignored");
        repeat (20) @(negedge clk);
        #1;
        check("no_second_frame_ncs", 32'(ncs), 32'd1);
        check("no_extra_done", 32'(done_cnt - done_base), 32'd1);

        // Back-to-back: second start in the done cycle
        loop_en = 1'b1;
        start_frame(1'b1, 7'h2A, 8'hC3);
        finish_frame(16'hAAC3, 1'b1, 8'hC3, "b2b_a");
        start_frame(1'b0, 7'h11, 8'h5E);
        check("b2b_accept_in_done", 32'(accept_cyc), 32'(done_cyc));
        finish_frame(16'h115E, 1'b1, 8'h5E, "b2b_b");
        check("b2b_ncs_high", 32'(last_ncs_high), 32'(N));

        // Reset after the 8th rising edge
        start_frame(1'b1, 7'h33, 8'h99);
        k = 0;
        while (mon_edges < 8 && k < 400) begin
            @(negedge clk);
            #1;
            k++;
        end
        check("edges_before_reset", 32'(mon_edges), 32'd8);
        check("sclk_high_at_reset", 32'(sclk), 32'd1);
        base  = done_cnt;
        rst_n = 1'b0;
        #1;
        check("mid_rst_ncs",   32'(ncs),   32'd1);
        check("mid_rst_sclk",  32'(sclk),  32'd0);
        check("mid_rst_copi",  32'(copi),  32'd0);
        check("mid_rst_busy",  32'(busy),  32'd0);
        check("mid_rst_rdata", 32'(rdata), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        #1;
        check("no_done_after_reset", 32'(done_cnt - base), 32'd0);
        start_frame(1'b1, 7'h33, 8'h99);
        finish_frame(16'hB399, 1'b1, 8'h99, "post_reset");

        // Random frames with random cipo
        loop_en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            r = 1'($urandom);
            a = 7'($urandom);
            d = 8'($urandom);
            start_frame(r, a, d);
            finish_frame({r, a, d}, 1'b0, 8'h00, $sformatf("rnd%0d", i));
        end
        repeat (10) @(negedge clk);

        check("protocol_violations", 32'(viol), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
